// File: rtl/bike_pkg.sv
// Shared types and constants for the bicycle computer arithmetic stages.
// Optional build macro: DIVIDER_ROUND_EN adds the ROUND state (half-up rounding).
package bike_pkg;

    localparam int unsigned DIV_WIDTH     = 16;
    localparam int unsigned DIV_OUT_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef DIVIDER_ROUND_EN
        ROUND = 2'd3,
`endif
        DONE  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_arbiter.sv
// Two-way round-robin arbiter; grants only while enabled (divider idle).
module div_arbiter
    import bike_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       en_i,
    output logic [1:0] gnt_c_o
);

    // last_q: 1 when channel 1 holds the most recent grant
    logic last_q, last_d;

    // Grant selection and pointer update
    always_comb begin
        gnt_c_o = 2'b00;
        if (en_i) begin
            if (req0_i && req1_i) begin
                gnt_c_o = last_q ? 2'b01 : 2'b10;
            end else if (req0_i) begin
                gnt_c_o = 2'b01;
            end else if (req1_i) begin
                gnt_c_o = 2'b10;
            end
        end
        last_d = last_q;
        if (gnt_c_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_c_o[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer register; resets so channel 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/shared_divider.sv
// Shared radix-2 restoring divider serving two request channels.
// Optional build macro: DIVIDER_ROUND_EN (round half-up, one extra cycle).
module shared_divider
    import bike_pkg::*;
#(
    parameter int unsigned WIDTH     = DIV_WIDTH,
    parameter int unsigned OUT_WIDTH = DIV_OUT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     dividend0,
    input  logic [WIDTH-1:0]     dividend1,
    input  logic [WIDTH-1:0]     divisor0,
    input  logic [WIDTH-1:0]     divisor1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [OUT_WIDTH-1:0] quotient,
    output logic                 sat,
    output logic                 dbz,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_t           state_q, state_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH:0]       quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ch_q, ch_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 done0_q, done0_d, done1_q, done1_d;
    logic [OUT_WIDTH-1:0] quotient_q, quotient_d;
    logic                 sat_q, sat_d, dbz_q, dbz_d, busy_q, busy_d;
    logic [WIDTH:0]       shifted;
    logic                 rem_ge;
    logic [1:0]           gnt_c;

    div_arbiter u_arb (
        .clk     (clock),
        .rst_n   (reset),
        .req0_i  (req0),
        .req1_i  (req1),
        .en_i    (state_q == IDLE),
        .gnt_c_o (gnt_c)
    );

    // Next-state, datapath step and registered-output computation
    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        quotient_d = quotient_q;
        sat_d      = sat_q;
        dbz_d      = dbz_q;
        shifted    = {rem_q, dvd_q[WIDTH-1]};
        rem_ge     = (shifted >= {1'b0, dvs_q});

        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    ch_d   = gnt_c[1];
                    dvd_d  = gnt_c[1] ? dividend1 : dividend0;
                    dvs_d  = gnt_c[1] ? divisor1 : divisor0;
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = CNT_W'(WIDTH);
                    gnt0_d = gnt_c[0];
                    gnt1_d = gnt_c[1];
                    state_d = (dvs_d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                rem_d = rem_ge ? WIDTH'(shifted - {1'b0, dvs_q}) : WIDTH'(shifted);
                quo_d = {quo_q[WIDTH-1:0], rem_ge};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef DIVIDER_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DIVIDER_ROUND_EN
            ROUND: begin
                // Half-up: bump when the remainder is at least half the divisor
                if ({rem_q, 1'b0} >= {1'b0, dvs_q}) begin
                    quo_d = quo_q + (WIDTH + 1)'(1);
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                if (dvs_q == '0) begin
                    quotient_d = '1;
                    sat_d      = 1'b0;
                    dbz_d      = 1'b1;
                end else if (|quo_q[WIDTH:OUT_WIDTH]) begin
                    quotient_d = '1;
                    sat_d      = 1'b1;
                    dbz_d      = 1'b0;
                end else begin
                    quotient_d = quo_q[OUT_WIDTH-1:0];
                    sat_d      = 1'b0;
                    dbz_d      = 1'b0;
                end
                done0_d = ~ch_q;
                done1_d = ch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            ch_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            quotient_q <= '0;
            sat_q      <= 1'b0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            quotient_q <= quotient_d;
            sat_q      <= sat_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign quotient = quotient_q;
    assign sat      = sat_q;
    assign dbz      = dbz_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_shared_divider.sv
// Self-checking bench for shared_divider: vector table, hand sequences, random ops.
module tb_shared_divider;

    localparam int unsigned W  = 16;
    localparam int unsigned OW = 12;
`ifdef DIVIDER_ROUND_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  dividend0 = '0, dividend1 = '0, divisor0 = '0, divisor1 = '0;
    logic          gnt0, gnt1, done0, done1, sat, dbz, busy;
    logic [OW-1:0] quotient;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    shared_divider dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .dividend0 (dividend0),
        .dividend1 (dividend1),
        .divisor0  (divisor0),
        .divisor1  (divisor1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .quotient  (quotient),
        .sat       (sat),
        .dbz       (dbz),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            ch;
        logic [W-1:0]  dvd;
        logic [W-1:0]  dvs;
        logic [OW-1:0] q;
        logic          sat;
        logic          dbz;
        int            lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return gnt0;
            1:       return gnt1;
            2:       return done0;
            default: return done1;
        endcase
    endfunction

    // Waits (sampling at negedges) for a pulse; a timeout is a failed check
    task automatic wait_for(input int which, input int budget, input string name,
                            output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sig(which) === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no pulse within %0d cycles", name, budget);
        end
    endtask

    // Reference: plain integer division with the saturation / divide-by-zero rules
    task automatic model(input logic [W-1:0] dvd, input logic [W-1:0] dvs, output vec_t v);
        int unsigned t, r;
        v.dvd = dvd;
        v.dvs = dvs;
        if (dvs == 0) begin
            v.q = '1; v.sat = 1'b0; v.dbz = 1'b1; v.lat = 1;
        end else begin
            t = 32'(dvd) / 32'(dvs);
            r = 32'(dvd) % 32'(dvs);
`ifdef DIVIDER_ROUND_EN
            if (2 * r >= 32'(dvs)) t = t + 1;
`endif
            v.sat = (t > 4095);
            v.q   = v.sat ? 12'hFFF : OW'(t);
            v.dbz = 1'b0;
            v.lat = LAT;
        end
    endtask

    task automatic set_req(input int ch, input logic val, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        if (ch == 0) begin
            req0 = val; dividend0 = dvd; divisor0 = dvs;
        end else begin
            req1 = val; dividend1 = dvd; divisor1 = dvs;
        end
    endtask

    // Scrambles a channel's operands after its grant; result must not change
    task automatic scramble(input int ch);
        if (ch == 0) begin
            dividend0 = W'($urandom); divisor0 = W'($urandom);
        end else begin
            dividend1 = W'($urandom); divisor1 = W'($urandom);
        end
    endtask

    // Waits for done of a granted channel, checks the result, drops the request
    task automatic finish_op(input int ch, input vec_t e, input int g, input string name);
        int d;
        bit ok;
        wait_for(2 + ch, 40, {name, "_done"}, d, ok);
        if (ok) begin
            chk({name, "_latency"}, 32'(d - g), 32'(e.lat));
            chk({name, "_quotient"}, 32'(quotient), 32'(e.q));
            chk({name, "_sat"}, 32'(sat), 32'(e.sat));
            chk({name, "_dbz"}, 32'(dbz), 32'(e.dbz));
            chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
            chk({name, "_other_done"}, 32'(ch == 0 ? done1 : done0), 32'd0);
        end
        if (ch == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic do_op(input int ch, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input vec_t e, input string name);
        int g;
        bit ok;
        set_req(ch, 1'b1, dvd, dvs);
        wait_for(ch, 40, {name, "_gnt"}, g, ok);
        if (ok) begin
            chk({name, "_busy_after_gnt"}, 32'(busy || e.dbz), 32'd1);
            scramble(ch);
            finish_op(ch, e, g, name);
        end else begin
            set_req(ch, 1'b0, '0, '0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vec_t e, e1;
        int   g;
        bit   ok;

        // Hand-computed table: channel, dividend, divisor, quotient, sat, dbz, latency
        vecs[0] = '{0, 16'd1000,  16'd7,     `ifdef DIVIDER_ROUND_EN 12'd143 `else 12'd142 `endif, 1'b0, 1'b0, LAT};
        vecs[1] = '{1, 16'd500,   16'd0,     12'd4095, 1'b0, 1'b1, 1};
        vecs[2] = '{0, 16'd65535, 16'd1,     12'd4095, 1'b1, 1'b0, LAT};
        vecs[3] = '{0, 16'd4095,  16'd1,     12'd4095, 1'b0, 1'b0, LAT};
        vecs[4] = '{1, 16'd4096,  16'd1,     12'd4095, 1'b1, 1'b0, LAT};
        vecs[5] = '{0, 16'd0,     16'd5,     12'd0,    1'b0, 1'b0, LAT};
        vecs[6] = '{1, 16'd65535, 16'd65535, 12'd1,    1'b0, 1'b0, LAT};
        vecs[7] = '{0, 16'd12,    16'd4096,  12'd0,    1'b0, 1'b0, LAT};
        vecs[8] = '{1, 16'd24575, 16'd6,     12'd4095, `ifdef DIVIDER_ROUND_EN 1'b1 `else 1'b0 `endif, 1'b0, LAT};
        vecs[9] = '{0, 16'd100,   16'd8,     `ifdef DIVIDER_ROUND_EN 12'd13 `else 12'd12 `endif, 1'b0, 1'b0, LAT};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({gnt0, gnt1, done0, done1, sat, dbz}), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Simultaneous requests after reset: ch0 first, ch1 one cycle after done0
        model(16'd1000, 16'd7, e);
        model(16'd300, 16'd3, e1);
        set_req(0, 1'b1, 16'd1000, 16'd7);
        set_req(1, 1'b1, 16'd300, 16'd3);
        wait_for(0, 5, "tie1_gnt0", g, ok);
        chk("tie1_no_gnt1", 32'(gnt1), 32'd0);
        if (ok) begin
            scramble(0);
            finish_op(0, e, g, "tie1_ch0");
            @(negedge clock);
            chk("tie1_gnt1_after_done0", 32'(gnt1), 32'd1);
            g = cyc;
            scramble(1);
            finish_op(1, e1, g, "tie1_ch1");
        end
        req0 = 1'b0; req1 = 1'b0;

        // Tie again: pointer sits at ch1, so ch0 wins
        model(16'd777, 16'd10, e);
        model(16'd9, 16'd0, e1);
        set_req(0, 1'b1, 16'd777, 16'd10);
        set_req(1, 1'b1, 16'd9, 16'd0);
        wait_for(0, 5, "tie2_gnt0", g, ok);
        chk("tie2_no_gnt1", 32'(gnt1), 32'd0);
        if (ok) begin
            finish_op(0, e, g, "tie2_ch0");
            @(negedge clock);
            chk("tie2_gnt1_after_done0", 32'(gnt1), 32'd1);
            g = cyc;
            finish_op(1, e1, g, "tie2_ch1");
        end
        req0 = 1'b0; req1 = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].ch, vecs[i].dvd, vecs[i].dvs, vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of RUN, request held through it
        model(16'd1000, 16'd7, e);
        set_req(0, 1'b1, 16'd1000, 16'd7);
        wait_for(0, 5, "rstmid_gnt0", g, ok);
        repeat (8) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_quotient", 32'(quotient), 32'd0);
        chk("rstmid_done0", 32'(done0), 32'd0);
        @(negedge clock);
        chk("rstmid_done0_held", 32'(done0), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_regrant", 32'(gnt0), 32'd1);
        g = cyc;
        finish_op(0, e, g, "rstmid_ch0");

        // ch1 arrives while ch0 is busy; served in the IDLE cycle after done0
        model(16'd65535, 16'd255, e);
        model(16'd5000, 16'd9, e1);
        set_req(0, 1'b1, 16'd65535, 16'd255);
        wait_for(0, 5, "late_gnt0", g, ok);
        repeat (3) @(negedge clock);
        set_req(1, 1'b1, 16'd5000, 16'd9);
        if (ok) begin
            finish_op(0, e, g, "late_ch0");
            @(negedge clock);
            chk("late_gnt1_after_done0", 32'(gnt1), 32'd1);
            g = cyc;
            scramble(1);
            finish_op(1, e1, g, "late_ch1");
        end
        req0 = 1'b0; req1 = 1'b0;

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            int           ch;
            ch = int'($urandom_range(0, 1));
            a  = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(0, 3));
                1:       b = W'($urandom_range(1, 40));
                default: b = W'($urandom);
            endcase
            model(a, b, e);
            do_op(ch, a, b, e, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_divider.md
# shared_divider

Sequential radix-2 restoring divider shared by the speed and average-speed stages of the bicycle computer. It sits directly upstream of both: each stage posts a dividend/divisor pair on its own request channel. The block arbitrates round-robin between the two channels, iterates one quotient bit per clock and returns a saturated quotient to the requesting channel. It replaces two private dividers with one, keeping area low next to `distance`, `timing` and `control`.

## Interface
- `WIDTH`, 16, width of the dividend, the divisor and the internal quotient/remainder.
- `OUT_WIDTH`, 12, width of the returned quotient; must be ≤ `WIDTH`.
- `clock`  input  1  single system clock; all state changes on its rising edge.
- `reset`  input  1  reset; one clock; reset is asynchronous and active-low.
- `req0`, `req1`  input  1  level request, channel 0 (speed) / channel 1 (average speed).
- `dividend0`, `dividend1`  input  WIDTH  unsigned dividend per channel.
- `divisor0`, `divisor1`  input  WIDTH  unsigned divisor per channel.
- `gnt0`, `gnt1`  output  1  one-cycle pulse: that channel's operands were captured this edge.
- `done0`, `done1`  output  1  one-cycle pulse: result for that channel is valid.
- `quotient`  output  OUT_WIDTH  result; holds until the next completion.
- `sat`  output  1  the true quotient exceeded 2^OUT_WIDTH−1; held with `quotient`.
- `dbz`  output  1  the divisor was zero; held with `quotient`.
- `busy`  output  1  high in every state except IDLE.

## Operation
- States: IDLE → RUN → [ROUND] → DONE → IDLE. ROUND exists only with `DIVIDER_ROUND_EN`.
- IDLE:
  - If any `req` is high, grant one channel, pulse its `gnt`, capture its dividend and divisor, clear the remainder, load the bit counter with `WIDTH`.
  - Go to RUN, or directly to DONE if the divisor is 0.
- Arbitration:
  - Single request: that channel wins.
  - Both requests: the channel not granted last wins.
  - The last-grant pointer resets to channel 1, so channel 0 wins the first tie after reset.
- RUN, one step per cycle, MSB first:
  - Shift the remainder left, bringing in the next dividend bit.
  - If remainder ≥ divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
  - After `WIDTH` steps, go to ROUND or DONE.
- ROUND: if 2·remainder ≥ divisor, increment the quotient (WIDTH+1-bit add, no wrap).
- DONE:
  - If the quotient > 2^OUT_WIDTH−1, drive all-ones and set `sat=1`; otherwise drive the low `OUT_WIDTH` bits and `sat=0`.
  - On divide-by-zero: `quotient` = all-ones, `sat=0`, `dbz=1`.
  - Pulse `done` of the granted channel; return to IDLE.
- Requester rules:
  - Hold `req` and operands stable from assertion until its `done`.
  - `req` still high in the cycle after `done` is a new request.
  - Operand changes after `gnt` are ignored.
- A request arriving while busy waits; no request is lost while it is held high.

## Timing
- Reset (asynchronous, `reset`=0):
  - State returns to IDLE and the last-grant pointer to channel 1.
  - `gnt*`, `done*`, `busy`, `sat`, `dbz` = 0; `quotient` = 0.
- Reset mid-operation aborts without any `done` pulse.
- Grant at edge E. `done` is high for the cycle after:
  - edge E+WIDTH+1 (17 for the default `WIDTH`) without rounding;
  - edge E+WIDTH+2 with rounding;
  - edge E+1 on divide-by-zero.
- Next grant at the earliest one edge after `done` (the IDLE cycle).
- Back-to-back period: WIDTH+2 cycles (WIDTH+3 with rounding).
- `quotient`, `sat` and `dbz` update on the same edge that raises `done`.

## Configuration
- `DIVIDER_ROUND_EN` defined: the ROUND state is present, the quotient is rounded half-up, and latency is +1 cycle.
- Not defined: truncating division, and no ROUND state exists in the encoding.

## Structure
- Shared package `bike_pkg`:
  - state enum typedef `div_state_t` (IDLE, RUN, ROUND, DONE);
  - constants `DIV_WIDTH=16` and `DIV_OUT_WIDTH=12`, reused by the speed and average-speed stages.
- One sub-module, `div_arbiter`: 2-way round-robin with a pointer register, fed by `req0`/`req1` and an IDLE-enable; it outputs the one-hot grant.
- The datapath (shift/subtract, counter, saturation) stays in `shared_divider`.

## Test plan
- Ch0 1000/7, `WIDTH=16`:
  - without the macro: `quotient`=142, `done0` at cycle 17 after `gnt0`, `sat=0`;
  - with the macro: 143, at cycle 18.
- `req0` and `req1` rise together after reset:
  - ch0 is served first, then ch1 with `gnt1` one cycle after `done0`;
  - both requests again: ch0 wins (pointer at ch1).
- Ch1 500/0 → `done1` one cycle after `gnt1`, `quotient`=4095, `dbz=1`, `sat=0`.
- Ch0 65535/1 → `quotient`=4095, `sat=1`; then 4095/1 → 4095, `sat=0`.
- `reset` low at RUN step 8:
  - immediately `busy=0` and `quotient=0`, with no `done` pulse;
  - a held `req0` is re-granted on the first edge after release.
- `req1` rises while ch0 is busy → `gnt1` in the IDLE cycle after `done0`; operands changed after `gnt1` do not affect the result.
